// File: rtl/vm1_qbus_dma_arb.sv
// Qbus DMA bus-mastership arbiter: requests the bus on behalf of NREQ local
// masters, takes the grant, waits for bus idle and hands ownership round-robin.
module vm1_qbus_dma_arb #(
  parameter int NREQ = 4,
  parameter int TOUT = 255
) (
  input  logic            pin_clk,
  input  logic            pin_dclo_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            dmr_out,
  input  logic            dmgi,
  output logic            dmgo,
  input  logic            sack_in,
  output logic            sack_out,
  input  logic            sync_in,
  input  logic            rply_in,
  output logic            tout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OWN,
    ST_REL
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              dmr_q, dmr_d;
  logic              dmgo_q, dmgo_d;
  logic              sack_q, sack_d;
  logic              tout_q, tout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     own_q, own_d;
  logic [PW-1:0]     rr_q, rr_d;

  logic              dmgi_s, sack_s, busy_s;
  logic [PW:0]       rot_sum;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     win_idx;
  logic              win_found;

  // Synchronizer bit order: {rply, sync, sack, dmgi}.
  assign dmgi_s = sync2_q[0];
  assign sack_s = sync2_q[1];
  assign busy_s = sync2_q[2] | sync2_q[3];

  // First requester at or after the round-robin pointer, circularly.
  always_comb begin
    rot_sum   = '0;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rot_sum = {1'b0, rr_q} + (PW+1)'(i);
      if (rot_sum >= (PW+1)'(NREQ)) rot_sum = rot_sum - (PW+1)'(NREQ);
      cand = rot_sum[PW-1:0];
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    dmr_d   = 1'b0;
    dmgo_d  = 1'b0;
    sack_d  = 1'b0;
    tout_d  = 1'b0;
    cnt_d   = cnt_q;
    own_d   = own_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        dmgo_d = dmgi_s;
        if (|req && !dmgi_s && !sack_s) begin
          state_d = ST_REQ;
          dmr_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (dmgi_s) begin
          state_d = ST_WAIT;
          sack_d  = 1'b1;
          cnt_d   = '0;
        end else if (req == '0) begin
          state_d = ST_IDLE;
        end else begin
          dmr_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!busy_s) begin
          if (win_found) begin
            state_d        = ST_OWN;
            own_d          = win_idx;
            sack_d         = 1'b1;
            gnt_d[win_idx] = 1'b1;
          end else begin
            state_d = ST_REL;
          end
        end else if (cnt_q == CW'(TOUT)) begin
          state_d = ST_REL;
          tout_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          sack_d = 1'b1;
        end
      end
      ST_OWN: begin
        if (!req[own_q]) begin
          state_d = ST_REL;
          rr_d    = (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;
        end else begin
          sack_d = 1'b1;
          gnt_d  = gnt_q;
        end
      end
      ST_REL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      state_q <= ST_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      gnt_q   <= '0;
      dmr_q   <= 1'b0;
      dmgo_q  <= 1'b0;
      sack_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= {rply_in, sync_in, sack_in, dmgi};
      sync2_q <= sync1_q;
      gnt_q   <= gnt_d;
      dmr_q   <= dmr_d;
      dmgo_q  <= dmgo_d;
      sack_q  <= sack_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt      = gnt_q;
  assign dmr_out  = dmr_q;
  assign dmgo     = dmgo_q;
  assign sack_out = sack_q;
  assign tout     = tout_q;

endmodule
